// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the seven-segment display path: drive polarities, digit limit,
// nibble types and the leading-zero suppression helper.
package seg_scan_driver_pkg;

  localparam logic ANODE_ON  = 1'b0;
  localparam logic ANODE_OFF = 1'b1;
  localparam logic DP_ON     = 1'b0;
  localparam logic DP_OFF    = 1'b1;

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned IDX_MAX_W  = $clog2(MAX_DIGITS);

  typedef logic [3:0] nibble_t;
  typedef nibble_t [MAX_DIGITS-1:0] nibble_vec_t;

  // Bit i set when digit i (i > 0) and every digit above it, up to n-1, hold zero.
  function automatic logic [MAX_DIGITS-1:0] lz_suppress_mask(nibble_vec_t v, int unsigned n);
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_run;
    mask     = '0;
    zero_run = 1'b1;
    for (int unsigned k = MAX_DIGITS; k > 0; k--) begin
      if (k <= n) begin
        zero_run  = zero_run & (v[k-1] == 4'h0);
        mask[k-1] = zero_run & (k > 1);
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot timer for the digit scanner: divides the clock into digit slots and walks the
// digit index, flagging the guard window and the frame wrap.
module scan_tick_gen #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned GUARD      = 16,
  parameter int unsigned IDX_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] digit_idx,
  output logic             in_guard,
  output logic             frame_wrap
);

  localparam int unsigned        TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]  GUARD_END  = TICK_W'(GUARD);
  localparam logic [IDX_W-1:0]   DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick_last;
  logic              digit_last;

  assign tick_last  = (tick_cnt == TICK_LAST);
  assign digit_last = (digit_idx == DIGIT_LAST);
  assign in_guard   = (tick_cnt < GUARD_END);
  assign frame_wrap = tick_last & digit_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      digit_idx <= '0;
    end else if (tick_last) begin
      tick_cnt  <= '0;
      digit_idx <= digit_last ? '0 : digit_idx + 1'b1;
    end else begin
      tick_cnt  <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode display scanner: double-buffered hex value, frame-aligned
// updates, leading-zero blanking and registered per-digit drive for the decoder stage.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned GUARD      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [3:0]              hex_out,
  output logic                    blank,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [IDX_W-1:0] digit_idx;
  logic             in_guard;
  logic             frame_wrap;

  scan_tick_gen #(
    .NUM_DIGITS (NUM_DIGITS),
    .TICK_DIV   (TICK_DIV),
    .GUARD      (GUARD),
    .IDX_W      (IDX_W)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_idx  (digit_idx),
    .in_guard   (in_guard),
    .frame_wrap (frame_wrap)
  );

  nibble_t [NUM_DIGITS-1:0] disp_reg;
  nibble_t [NUM_DIGITS-1:0] pend_reg;
  logic                     pend_full;
  logic                     accept;

  assign load_ready = ~pend_full;
  assign accept     = load_valid & load_ready;

  // Transfer and accept never coincide: a boundary transfer implies pend_full, hence no ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_reg  <= '0;
      pend_reg  <= '0;
      pend_full <= 1'b0;
    end else if (frame_wrap && pend_full) begin
      disp_reg  <= pend_reg;
      pend_full <= 1'b0;
    end else if (accept) begin
      pend_reg  <= load_data;
      pend_full <= 1'b1;
    end
  end

  nibble_vec_t             disp_ext;
  logic [MAX_DIGITS-1:0]   lz_mask_all;
  logic                    suppress;
  logic                    dark;
  logic [NUM_DIGITS-1:0]   anode_d;
  logic                    dp_d;

  always_comb begin
    disp_ext                   = '0;
    disp_ext[NUM_DIGITS-1:0]   = disp_reg;
  end

  assign lz_mask_all = lz_suppress_mask(disp_ext, NUM_DIGITS);
  assign suppress    = blank_lz & lz_mask_all[IDX_MAX_W'(digit_idx)];
  assign dark        = in_guard | suppress;

  always_comb begin
    anode_d = {NUM_DIGITS{ANODE_OFF}};
    if (!dark) begin
      anode_d[digit_idx] = ANODE_ON;
    end
  end

  assign dp_d = (!dark && dp_mask[digit_idx]) ? DP_ON : DP_OFF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_n    <= {NUM_DIGITS{ANODE_OFF}};
      hex_out    <= 4'h0;
      blank      <= 1'b1;
      dp_n       <= DP_OFF;
      frame_done <= 1'b0;
    end else begin
      anode_n    <= anode_d;
      hex_out    <= disp_reg[digit_idx];
      blank      <= dark;
      dp_n       <= dp_d;
      frame_done <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a time-based reference model queues the expected
// drive for every clock, and a monitor compares the registered outputs half a cycle later.
module tb_seg_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned TD = 8;
  localparam int unsigned GD = 2;
  localparam int unsigned FRAME = ND * TD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [15:0]   load_data = '0;
  logic          blank_lz = 1'b0;
  logic [ND-1:0] dp_mask = '0;
  logic [3:0]    hex_out;
  logic          blank;
  logic [ND-1:0] anode_n;
  logic          dp_n;
  logic          frame_done;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS (ND),
    .TICK_DIV   (TD),
    .GUARD      (GD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .hex_out    (hex_out),
    .blank      (blank),
    .anode_n    (anode_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] anode;
    logic [3:0] hex;
    logic       blank;
    logic       dp;
    logic       fd;
    logic       ready;
  } obs_t;

  obs_t        exp_q[$];
  logic [15:0] pend_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b required %b", name, $time, act, exp);
    end
  endtask

  // Reference model: slot position is pure arithmetic on the clock count since reset
  // release; the displayed value only changes at frame boundaries.
  initial begin
    int          s;
    int          tick;
    int          dig;
    bit          dark;
    bit          boundary;
    logic [15:0] disp;
    obs_t        e;
    s    = 0;
    disp = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        s    = 0;
        disp = '0;
        pend_q.delete();
        exp_q.delete();
      end else begin
        tick     = s % TD;
        dig      = (s / TD) % ND;
        boundary = ((s % FRAME) == FRAME - 1);
        dark     = (tick < GD) || (blank_lz && dig > 0 && (disp >> (4 * dig)) == 16'h0);
        e.anode  = dark ? 4'hF : ~(4'b0001 << dig);
        e.hex    = 4'(disp >> (4 * dig));
        e.blank  = dark;
        e.dp     = dark ? 1'b1 : ~dp_mask[dig];
        e.fd     = boundary;
        if (boundary && pend_q.size() > 0) begin
          disp = pend_q.pop_front();
        end else if (load_valid && pend_q.size() == 0) begin
          pend_q.push_back(load_data);
        end
        e.ready = (pend_q.size() == 0);
        exp_q.push_back(e);
        s++;
      end
    end
  end

  // Monitor
  initial begin
    obs_t e;
    obs_t act;
    forever begin
      @(negedge clk);
      act = {anode_n, hex_out, blank, dp_n, frame_done, load_ready};
      if (!rst_n) begin
        check("reset_state", 32'(act), 32'({4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1}));
      end else if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL no_expectation @%0t: got %b required a queued entry", $time, act);
      end else begin
        e = exp_q.pop_front();
        check("drive{anode,hex,blank,dp,fd,ready}", 32'(act), 32'(e));
      end
    end
  end

  task automatic send(input logic [15:0] v);
    int waited = 0;
    load_valid = 1'b1;
    load_data  = v;
    @(negedge clk);
    while (!load_ready && waited < 4 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    check("send_ready_within_bound", 32'(load_ready), 32'd1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_lit(output bit found);
    int waited = 0;
    found = 1'b0;
    while (!found && waited < 2 * FRAME) begin
      @(negedge clk);
      found = (anode_n != 4'hF);
      waited++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    logic [15:0] r;
    rst_n = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      load_valid = 1'($urandom);
      load_data  = 16'($urandom);
      blank_lz   = 1'($urandom);
      dp_mask    = 4'($urandom);
    end
    @(negedge clk);
    #1;
    load_valid = 1'b0;
    blank_lz   = 1'b0;
    dp_mask    = '0;
    rst_n      = 1'b1;

    repeat (10) @(posedge clk);
    #1;
    send(16'h12A4);
    repeat (3 * FRAME) @(posedge clk);

    #1;
    blank_lz = 1'b1;
    send(16'h0050);
    repeat (2 * FRAME) @(posedge clk);
    #1;
    send(16'h0000);
    repeat (2 * FRAME) @(posedge clk);

    #1;
    blank_lz = 1'b0;
    send(16'h1111);
    send(16'h2222);
    send(16'h3333);
    repeat (2 * FRAME) @(posedge clk);

    #1;
    dp_mask = 4'b0010;
    send(16'h8888);
    repeat (2 * FRAME) @(posedge clk);

    // Asynchronous reset in the middle of a lit slot
    wait_lit(found);
    check("lit_before_async_reset", 32'(found), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_anode_off", 32'(anode_n), 32'hF);
    check("async_blank", 32'(blank), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    wait_lit(found);
    check("lit_after_release", 32'(found), 32'd1);
    check("first_lit_digit0", 32'(anode_n), 32'hE);

    repeat (400) begin
      @(posedge clk);
      #1;
      r          = 16'($urandom);
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = r >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) begin
        blank_lz = 1'($urandom);
        dp_mask  = 4'($urandom);
      end
    end
    #1;
    load_valid = 1'b0;
    repeat (2 * FRAME) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
